fp_norm_pipe: RTL and testbench
===============================

# fp_norm_pipe

Parametrised, two-stage pipelined normaliser for the floating-point add/subtract datapath. It sits between the mantissa adder stage and the rounding stage. It accepts the raw signed-magnitude sum with carry and guard bits, and locates the leading one itself, with no external shift position. It renormalises by a 1-bit right shift on carry-out or an N-bit left shift on cancellation, adjusts the exponent with overflow/underflow/zero detection, and moves data under a valid/ready handshake.

## Interface
- MENT_WIDTH, 23, stored fraction bits.
- EXPO_WIDTH, 8, biased exponent bits.
- GUARD_WIDTH, 3, guard/round/sticky bits below the fraction LSB.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_sign  input  1  result sign from the adder stage.
- in_exp  input  EXPO_WIDTH  larger operand exponent (biased).
- in_mant  input  MENT_WIDTH+GUARD_WIDTH+2  raw sum: carry bit at MSB, then hidden bit, fraction, guard bits.
- out_valid  output  1  output beat valid.
- out_ready  input  1  rounding stage accepts output.
- out_sign  output  1  passed-through sign (forced 0 on zero result).
- out_exp  output  EXPO_WIDTH  normalised exponent.
- out_mant  output  MENT_WIDTH+GUARD_WIDTH+1  hidden bit, fraction, guard bits; hidden bit = 1 unless special.
- out_ovf  output  1  exponent overflow, result is infinity.
- out_unf  output  1  underflow, flushed to zero.
- out_zero  output  1  exact zero sum.

## Operation
- Let W = MENT_WIDTH+GUARD_WIDTH+2 and H = W-2, the hidden-bit index.
- Stage 1 registers sign, exp, mant, the carry flag (mant[W-1]), the zero flag (mant==0), and lzc. lzc = count of zeros from bit H downward to the first one, with width $clog2(W).
- Stage 2 computes the output using the first matching case, in priority order:
  - Zero: exp=0, mant=0, sign=0, out_zero=1.
  - Carry: mant = mant[W-1:1] with the LSB ORed with dropped bit 0 (sticky), and exp+1. If exp+1 equals all-ones, then exp=all-ones, mant=0, out_ovf=1.
  - Left shift (lzc>0): if lzc >= exp, flush to zero with exp=0, mant=0, sign kept, out_unf=1. Otherwise mant<<lzc and exp-lzc.
  - Already normal: pass-through.
- Flags are mutually exclusive per beat.
- Input exp = all-ones (inf/NaN) is not handled here; the upstream special-case path bypasses this block.
- Arithmetic on exponent uses EXPO_WIDTH+1 bits internally; the compare is unsigned.

## Timing
- Latency: 2 cycles from accepted input to out_valid, when out_ready stays high.
- Throughput: one beat per cycle.
- Global stall enable: en = out_ready || !out_valid.
  - in_ready = en; both stages advance only when en=1.
  - A beat is accepted when in_valid && in_ready.
- Stage-1 valid loads in_valid when en. Stage-2 valid (out_valid) loads stage-1 valid when en.
- Outputs hold stable while out_valid && !out_ready.
- in_ready may depend combinationally on out_ready; there is no other comb path from input to output.
- Reset: both valid bits = 0; out_exp, out_mant, out_sign and all flags = 0; in_ready = 1 after reset.
- Reset asserted mid-stream discards all in-flight beats immediately; no beat is emitted after deassert until a new accept.

## Structure
- Shared package fp_pkg holds:
  - default width constants (MENT_WIDTH, EXPO_WIDTH, GUARD_WIDTH);
  - derived W and shift-width localparams;
  - a flags typedef {ovf, unf, zero}, reused by the rounding stage.
- One sub-module: fp_lzc, a parametrised combinational leading-zero counter, WIDTH and returns count with width $clog2(WIDTH+1).
- Target 150-250 lines RTL total.

## Test plan
Defaults: W=28; out_ready=1 unless stated.
- Pass-through: in_mant=28'h4000000, exp=0x80 -> after 2 cycles out_mant=27'h4000000, exp=0x80, flags 0.
- Carry with sticky: in_mant=28'h8000001, exp=0x80 -> out_mant=27'h4000001, exp=0x81.
- Cancellation: in_mant=28'h0000080, exp=0x80 (lzc=19) -> out_mant=27'h4000000, exp=0x6D.
- Specials:
  - carry with exp=0xFE -> exp=0xFF, mant=0, out_ovf=1;
  - in_mant=0 -> out_zero=1, sign=0;
  - in_mant=28'h0000080, exp=0x10 -> out_unf=1, exp=0, mant=0.
- Backpressure: stream 4 beats, drop out_ready for 3 cycles mid-stream -> in_ready low while stalled, outputs held, all 4 beats emerge in order with no loss or duplication.
- Reset mid-stream: assert rst with 2 beats in flight -> out_valid=0 in the same cycle, all outputs 0, no stale beat after release.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Purpose  : Shared definitions for the floating-point add/sub datapath:
//            default field widths, derived sum/shift widths and the
//            exception flag bundle passed on to the rounding stage.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

    // Default IEEE-754 single-precision field widths
    localparam int FP_MENT_WIDTH  = 23;
    localparam int FP_EXPO_WIDTH  = 8;
    localparam int FP_GUARD_WIDTH = 3;

    // Raw adder sum: carry + hidden + fraction + guard bits
    localparam int FP_W           = FP_MENT_WIDTH + FP_GUARD_WIDTH + 2;
    // Width of a left-shift amount / leading-zero count over the sum
    localparam int FP_SHIFT_WIDTH = $clog2(FP_W);

    // Exception flags, mutually exclusive per beat
    typedef struct packed {
        logic ovf;
        logic unf;
        logic zero;
    } fp_flags_t;

endpackage
`default_nettype wire

// File: rtl/fp_norm_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_norm_pipe_if
// Purpose  : Valid/ready handshake bundle between the mantissa adder, the
//            normaliser and the rounding stage.
// Ports    : in_*  - raw sum beat from the adder (valid/ready)
//            out_* - normalised beat plus flags to rounding (valid/ready)
//            modport slave  - normaliser view
//            modport master - upstream/downstream environment view
// Revision : 1.0 - initial release
// ============================================================================
interface fp_norm_pipe_if
    import fp_pkg::*;
#(
    parameter int MENT_WIDTH  = FP_MENT_WIDTH,
    parameter int EXPO_WIDTH  = FP_EXPO_WIDTH,
    parameter int GUARD_WIDTH = FP_GUARD_WIDTH
);
    localparam int W = MENT_WIDTH + GUARD_WIDTH + 2;

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sign;
    logic [EXPO_WIDTH-1:0] in_exp;
    logic [W-1:0]          in_mant;

    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sign;
    logic [EXPO_WIDTH-1:0] out_exp;
    logic [W-2:0]          out_mant;
    logic                  out_ovf;
    logic                  out_unf;
    logic                  out_zero;

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_mant,
               out_ovf, out_unf, out_zero
    );

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_mant,
               out_ovf, out_unf, out_zero
    );

endinterface
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
// Module   : fp_lzc
// Purpose  : Combinational leading-zero counter. Counts zeros from the MSB
//            down to the first one; an all-zero input returns WIDTH.
// Ports    : data  [WIDTH-1:0]            - vector to scan
//            count [$clog2(WIDTH+1)-1:0]  - number of leading zeros
// Revision : 1.0 - initial release
// ============================================================================
module fp_lzc #(
    parameter int WIDTH = 27
) (
    input  wire logic [WIDTH-1:0]             data,
    output      logic [$clog2(WIDTH+1)-1:0]   count
);
    localparam int CW = $clog2(WIDTH + 1);

    // Ascending scan: the highest set bit is the last to write the count.
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                count = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_norm_pipe
// Purpose  : Two-stage pipelined normaliser between the mantissa adder and
//            the rounding stage. Stage 1 captures the raw sum and finds its
//            leading one; stage 2 renormalises (1-bit right shift on carry,
//            left shift on cancellation), adjusts the exponent and raises
//            overflow / underflow / zero flags.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - fp_norm_pipe_if.slave (in_* beat in, out_* beat out)
// Revision : 1.0 - initial release
// ============================================================================
module fp_norm_pipe
    import fp_pkg::*;
#(
    parameter int MENT_WIDTH  = FP_MENT_WIDTH,
    parameter int EXPO_WIDTH  = FP_EXPO_WIDTH,
    parameter int GUARD_WIDTH = FP_GUARD_WIDTH
) (
    input wire logic       clk,
    input wire logic       rst,
    fp_norm_pipe_if.slave  bus
);
    localparam int W   = MENT_WIDTH + GUARD_WIDTH + 2;
    localparam int H   = W - 2;                 // hidden-bit index
    localparam int SW  = $clog2(W);             // lzc / shift width
    localparam int EW  = EXPO_WIDTH;
    localparam int EW1 = EXPO_WIDTH + 1;        // exponent math with headroom

    // ------------------------------------------------------------------
    // Global stall: both stages move together whenever the output slot
    // is empty or being drained.
    // ------------------------------------------------------------------
    logic en;
    logic out_valid_q;

    assign en           = bus.out_ready || !out_valid_q;
    assign bus.in_ready = en;

    // ------------------------------------------------------------------
    // Stage 1: capture sum, carry/zero flags and leading-zero count
    // ------------------------------------------------------------------
    logic [SW-1:0] lzc_in;

    fp_lzc #(
        .WIDTH (H + 1)
    ) u_lzc (
        .data  (bus.in_mant[H:0]),
        .count (lzc_in)
    );

    logic          s1_valid;
    logic          s1_sign;
    logic [EW-1:0] s1_exp;
    logic [W-1:0]  s1_mant;
    logic          s1_carry;
    logic          s1_zero;
    logic [SW-1:0] s1_lzc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_carry <= 1'b0;
            s1_zero  <= 1'b0;
            s1_lzc   <= '0;
        end else if (en) begin
            s1_valid <= bus.in_valid;
            s1_sign  <= bus.in_sign;
            s1_exp   <= bus.in_exp;
            s1_mant  <= bus.in_mant;
            s1_carry <= bus.in_mant[W-1];
            s1_zero  <= (bus.in_mant == '0);
            s1_lzc   <= lzc_in;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational normalisation, first matching case wins
    // ------------------------------------------------------------------
    logic [EW1-1:0] exp_ext;
    logic [EW1-1:0] exp_inc;
    logic [EW1-1:0] lzc_ext;
    logic [W-2:0]   mant_shl;

    logic           nxt_sign;
    logic [EW-1:0]  nxt_exp;
    logic [W-2:0]   nxt_mant;
    fp_flags_t      nxt_flags;

    assign exp_ext  = {1'b0, s1_exp};
    assign exp_inc  = exp_ext + EW1'(1);
    assign lzc_ext  = EW1'(s1_lzc);
    assign mant_shl = s1_mant[W-2:0] << s1_lzc;

    always_comb begin
        nxt_sign  = s1_sign;
        nxt_exp   = s1_exp;
        nxt_mant  = s1_mant[W-2:0];
        nxt_flags = '0;

        if (s1_zero) begin
            nxt_sign       = 1'b0;
            nxt_exp        = '0;
            nxt_mant       = '0;
            nxt_flags.zero = 1'b1;
        end else if (s1_carry) begin
            if (exp_inc >= {1'b0, {EW{1'b1}}}) begin
                nxt_exp       = '1;
                nxt_mant      = '0;
                nxt_flags.ovf = 1'b1;
            end else begin
                nxt_exp  = exp_inc[EW-1:0];
                // bit shifted out is folded into the sticky LSB
                nxt_mant = {s1_mant[W-1:2], s1_mant[1] | s1_mant[0]};
            end
        end else if (s1_lzc != '0) begin
            // A shift that would take the exponent to zero or below
            // cannot be represented as a normal number: flush.
            if (lzc_ext >= exp_ext) begin
                nxt_exp       = '0;
                nxt_mant      = '0;
                nxt_flags.unf = 1'b1;
            end else begin
                nxt_exp  = s1_exp - EW'(s1_lzc);
                nxt_mant = mant_shl;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 output registers
    // ------------------------------------------------------------------
    logic          out_sign_q;
    logic [EW-1:0] out_exp_q;
    logic [W-2:0]  out_mant_q;
    fp_flags_t     out_flags_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_mant_q  <= '0;
            out_flags_q <= '0;
        end else if (en) begin
            out_valid_q <= s1_valid;
            out_sign_q  <= nxt_sign;
            out_exp_q   <= nxt_exp;
            out_mant_q  <= nxt_mant;
            out_flags_q <= nxt_flags;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sign  = out_sign_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_mant  = out_mant_q;
    assign bus.out_ovf   = out_flags_q.ovf;
    assign bus.out_unf   = out_flags_q.unf;
    assign bus.out_zero  = out_flags_q.zero;

endmodule
`default_nettype wire

// File: tb/tb_fp_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_norm_pipe
// Purpose  : Directed self-checking bench for fp_norm_pipe: reset state,
//            normalisation cases, exception flags, backpressure and
//            mid-stream reset.
// Ports    : none (top-level bench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_norm_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    fp_norm_pipe_if bus ();

    fp_norm_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // One beat in, wait (bounded) for it to emerge, compare every field.
    task automatic run_vec(input string tag,
                           input logic s, input logic [7:0] e, input logic [27:0] m,
                           input logic xs, input logic [7:0] xe, input logic [26:0] xm,
                           input logic [2:0] xf);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_mant  = m;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 6) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, n, 2);
        check({tag, "_sign"}, bus.out_sign, xs);
        check({tag, "_exp"}, bus.out_exp, xe);
        check({tag, "_mant"}, bus.out_mant, xm);
        check({tag, "_flags"}, {bus.out_ovf, bus.out_unf, bus.out_zero}, xf);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int tx, rx, stalls, seen;
        logic stall_prev;
        logic [7:0]  held_exp;
        logic [26:0] held_mant;

        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.out_ready = 1'b1;

        // ---------------- reset state ----------------
        #3;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_outputs", {bus.out_sign, bus.out_exp, bus.out_mant}, 0);
        check("rst_flags", {bus.out_ovf, bus.out_unf, bus.out_zero}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ---------------- directed vectors ----------------
        run_vec("pass",     1'b1, 8'h80, 28'h4000000, 1'b1, 8'h80, 27'h4000000, 3'b000);
        run_vec("carry",    1'b0, 8'h80, 28'h8000001, 1'b0, 8'h81, 27'h4000001, 3'b000);
        run_vec("cancel",   1'b1, 8'h80, 28'h0000080, 1'b1, 8'h6D, 27'h4000000, 3'b000);
        run_vec("ovf",      1'b1, 8'hFE, 28'h8000000, 1'b1, 8'hFF, 27'h0000000, 3'b100);
        run_vec("zero",     1'b1, 8'h55, 28'h0000000, 1'b0, 8'h00, 27'h0000000, 3'b001);
        run_vec("unf",      1'b1, 8'h10, 28'h0000080, 1'b1, 8'h00, 27'h0000000, 3'b010);
        run_vec("unf_eq",   1'b0, 8'h01, 28'h2000000, 1'b0, 8'h00, 27'h0000000, 3'b010);
        run_vec("shift1",   1'b0, 8'h02, 28'h2000001, 1'b0, 8'h01, 27'h4000002, 3'b000);
        run_vec("carry_fd", 1'b0, 8'hFD, 28'hC000002, 1'b0, 8'hFE, 27'h6000001, 3'b000);

        // ---------------- backpressure ----------------
        repeat (3) @(negedge clk);
        tx = 0; rx = 0; stalls = 0; stall_prev = 1'b0;
        held_exp = '0; held_mant = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.out_ready = !(c >= 3 && c <= 5);
            bus.in_valid  = (tx < 4);
            bus.in_sign   = tx[0];
            bus.in_exp    = 8'h40 + 8'(tx);
            bus.in_mant   = 28'h4000000 | 28'(tx);
            #1;
            if (bus.out_valid && !bus.out_ready) begin
                stalls++;
                check("bp_in_ready_low", bus.in_ready, 0);
                if (stall_prev) begin
                    check("bp_hold_exp", bus.out_exp, held_exp);
                    check("bp_hold_mant", bus.out_mant, held_mant);
                end
                held_exp   = bus.out_exp;
                held_mant  = bus.out_mant;
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                check("bp_order_exp", bus.out_exp, 8'h40 + 8'(rx));
                check("bp_order_mant", bus.out_mant, 27'h4000000 | 27'(rx));
                rx++;
            end
            if (bus.in_valid && bus.in_ready) tx++;
        end
        check("bp_stall_cycles", stalls, 3);
        check("bp_sent", tx, 4);
        check("bp_received", rx, 4);

        // ---------------- reset mid-stream ----------------
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sign   = 1'b1;
        bus.in_exp    = 8'h22;
        bus.in_mant   = 28'h4000000;
        @(negedge clk);
        bus.in_exp    = 8'h23;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        #1;
        check("mid_pre_valid", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_outputs", {bus.out_sign, bus.out_exp, bus.out_mant}, 0);
        check("mid_rst_flags", {bus.out_ovf, bus.out_unf, bus.out_zero}, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("mid_no_stale", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
